// File: rtl/signed_muldiv_ctrl_pkg.sv
// Shared definitions for the signed multiply/divide sequencer: opcode
// encodings, FSM state encoding and a small opcode-class helper.
package signed_muldiv_ctrl_pkg;

    localparam logic [1:0] OP_MUL  = 2'b00;  // low half of signed product
    localparam logic [1:0] OP_MULH = 2'b01;  // high half of signed product
    localparam logic [1:0] OP_DIV  = 2'b10;  // quotient, truncated toward zero
    localparam logic [1:0] OP_REM  = 2'b11;  // remainder, sign of dividend

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // DIV and REM share the divide datapath; MUL and MULH share the multiplier.
    function automatic logic is_div_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// Combinational single iteration of the shared multiply/divide datapath.
// The 2*WIDTH-bit accumulator is {hi, lo}:
//   multiply: hi = partial product, lo = remaining multiplier bits (LSB first)
//   divide:   hi = partial remainder, lo = remaining dividend bits (MSB first)
//             with quotient bits filling in from the bottom
// Ports:
//   mode_div_i  1        1 = restoring divide step, 0 = shift-add multiply step
//   acc_i       2*WIDTH  current accumulator / partial remainder
//   operand_i   WIDTH    multiplicand magnitude / divisor magnitude
//   acc_o       2*WIDTH  next accumulator; in divide mode the LSB is left 0
//   q_bit_o     1        quotient bit of this divide step (0 in multiply mode)
module muldiv_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic                 mode_div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     operand_i,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic                 q_bit_o
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] rem_diff;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        acc_o   = '0;
        q_bit_o = 1'b0;

        // Carry out of the add is kept and shifted down into the top bit.
        mul_sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        // Partial remainder shifted left with the next dividend bit appended.
        rem_shift = acc_i[2*WIDTH-1:WIDTH-1];
        rem_diff  = rem_shift - {1'b0, operand_i};

        if (mode_div_i) begin
            q_bit_o = (rem_shift >= {1'b0, operand_i});
            // Remainder stays below the divisor, so WIDTH bits always hold it.
            acc_o   = {(q_bit_o ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                       acc_i[WIDTH-2:0], 1'b0};
        end else begin
            acc_o   = {mul_sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/signed_muldiv_ctrl.sv
// Multi-cycle signed multiply/divide sequencer. Accepts one operation per
// start handshake, iterates WIDTH cycles on operand magnitudes, applies sign
// correction and special cases, then holds the result until accepted.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_valid/ready   request handshake (ready only in IDLE)
//   opcode              00 MUL, 01 MULH, 10 DIV, 11 REM
//   operand_a/b         signed operands (multiplicand/dividend, multiplier/divisor)
//   flush               synchronous abort of any operation in flight
//   result_valid/ready  result handshake
//   result              selected result
//   div_by_zero         DIV/REM with operand_b == 0, qualified by result_valid
//   busy                high whenever not IDLE
module signed_muldiv_ctrl
    import signed_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [1:0]       opcode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic                 a_neg_q;
    logic                 b_neg_q;
    logic                 b_zero_q;
    logic [WIDTH-1:0]     b_mag_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     result_q;
    logic                 result_valid_q;
    logic                 div_by_zero_q;

    // Unsigned magnitudes: MIN_INT maps to 2^(WIDTH-1), which fits in WIDTH bits.
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    assign a_mag = operand_a[WIDTH-1] ? -operand_a : operand_a;
    assign b_mag = operand_b[WIDTH-1] ? -operand_b : operand_b;

    logic [2*WIDTH-1:0]   acc_step;
    logic                 q_bit;
    logic [2*WIDTH-1:0]   acc_d;

    muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
        .mode_div_i (is_div_op(op_q)),
        .acc_i      (acc_q),
        .operand_i  (b_mag_q),
        .acc_o      (acc_step),
        .q_bit_o    (q_bit)
    );

    // The step leaves the LSB free in divide mode; the quotient bit enters there.
    assign acc_d = acc_step | {{(2*WIDTH-1){1'b0}}, q_bit};

    // Sign correction and special-case selection, registered in FIX.
    logic [2*WIDTH-1:0]   prod_signed;
    logic [WIDTH-1:0]     quo_signed;
    logic [WIDTH-1:0]     rem_signed;
    logic [WIDTH-1:0]     fix_result_d;
    logic                 fix_dbz_d;

    always_comb begin
        prod_signed = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
        quo_signed  = (a_neg_q ^ b_neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_signed  = a_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        fix_dbz_d   = is_div_op(op_q) && b_zero_q;
        fix_result_d = '0;
        case (op_q)
            OP_MUL:  fix_result_d = prod_signed[WIDTH-1:0];
            OP_MULH: fix_result_d = prod_signed[2*WIDTH-1:WIDTH];
            OP_DIV:  fix_result_d = b_zero_q ? '1  : quo_signed;
            OP_REM:  fix_result_d = b_zero_q ? a_q : rem_signed;
            default: fix_result_d = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            op_q           <= '0;
            a_q            <= '0;
            a_neg_q        <= 1'b0;
            b_neg_q        <= 1'b0;
            b_zero_q       <= 1'b0;
            b_mag_q        <= '0;
            acc_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            div_by_zero_q  <= 1'b0;
        end else if (flush) begin
            // Abort wins over both handshakes in the same cycle.
            state_q        <= S_IDLE;
            result_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_valid && start_ready) begin
                        op_q     <= opcode;
                        a_q      <= operand_a;
                        a_neg_q  <= operand_a[WIDTH-1];
                        b_neg_q  <= operand_b[WIDTH-1];
                        b_zero_q <= (operand_b == '0);
                        b_mag_q  <= b_mag;
                        acc_q    <= {{WIDTH{1'b0}}, a_mag};
                        cnt_q    <= CNT_LAST;
                        state_q  <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_FIX: begin
                    result_q       <= fix_result_d;
                    div_by_zero_q  <= fix_dbz_d;
                    result_valid_q <= 1'b1;
                    state_q        <= S_DONE;
                end
                S_DONE: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                        state_q        <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign start_ready  = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign div_by_zero  = div_by_zero_q;

endmodule

// File: tb/tb_signed_muldiv_ctrl.sv
// Directed self-checking bench for signed_muldiv_ctrl (WIDTH = 32).
module tb_signed_muldiv_ctrl;
    import signed_muldiv_ctrl_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic          clk;
    logic          rst_n;
    logic          start_valid;
    logic          start_ready;
    logic [1:0]    opcode;
    logic [W-1:0]  operand_a;
    logic [W-1:0]  operand_b;
    logic          flush;
    logic          result_valid;
    logic          result_ready;
    logic [W-1:0]  result;
    logic          div_by_zero;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    signed_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .opcode       (opcode),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .flush        (flush),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .div_by_zero  (div_by_zero),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drives a request for one cycle; returns just after the accepting edge.
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        opcode      = op;
        operand_a   = a;
        operand_b   = b;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    // Counts edges from the accepting edge (edge 1) until result_valid, bounded.
    task automatic wait_result(output int cycles);
        cycles = 1;
        while (!result_valid && cycles < LAT + 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        check({tag, " valid_drop"}, result_valid, 1'b0);
        check({tag, " ready_back"}, start_ready, 1'b1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res, input logic exp_dbz);
        int cycles;
        start_op(op, a, b);
        wait_result(cycles);
        check({tag, " latency"}, cycles, LAT);
        check({tag, " result"}, result, exp_res);
        check({tag, " dbz"}, div_by_zero, exp_dbz);
        release_result(tag);
    endtask

    // Watches for any result_valid during a window after an abort.
    task automatic expect_silence(input string tag, input int n);
        int rises = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (result_valid) rises++;
        end
        check({tag, " no_result"}, rises, 0);
    endtask

    initial begin
        int cycles;
        rst_n        = 1'b0;
        start_valid  = 1'b0;
        opcode       = OP_MUL;
        operand_a    = '0;
        operand_b    = '0;
        flush        = 1'b0;
        result_ready = 1'b0;

        // Reset values
        #3;
        check("rst start_ready", start_ready, 1'b1);
        check("rst result_valid", result_valid, 1'b0);
        check("rst result", result, '0);
        check("rst dbz", div_by_zero, 1'b0);
        check("rst busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Multiply, including MIN_INT magnitudes
        run_op("mul -7x6",     OP_MUL,  32'hFFFF_FFF9, 32'd6,        32'hFFFF_FFD6, 1'b0);
        run_op("mulh -7x6",    OP_MULH, 32'hFFFF_FFF9, 32'd6,        32'hFFFF_FFFF, 1'b0);
        run_op("mulh min*min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        run_op("mul min*min",  OP_MUL,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0);

        // Divide sign rules
        run_op("div -7/2",  OP_DIV, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0);
        run_op("rem -7/2",  OP_REM, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0);
        run_op("div 7/-2",  OP_DIV, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        run_op("rem 7/-2",  OP_REM, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

        // Special cases
        run_op("div 5/0",      OP_DIV, 32'd5,        32'd0,        32'hFFFF_FFFF, 1'b1);
        run_op("rem 5/0",      OP_REM, 32'd5,        32'd0,        32'h0000_0005, 1'b1);
        run_op("div min/-1",   OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        run_op("rem min/-1",   OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);

        // Backpressure: result held, requests ignored while in DONE
        start_op(OP_DIV, 32'd100, 32'd7);
        wait_result(cycles);
        check("bp latency", cycles, LAT);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start_valid = (i == 4);
            opcode      = OP_MUL;
            operand_a   = 32'd2;
            operand_b   = 32'd2;
            @(posedge clk);
            #1;
            check("bp result", result, 32'h0000_000E);
            check("bp valid", result_valid, 1'b1);
            check("bp start_ready", start_ready, 1'b0);
        end
        @(negedge clk);
        start_valid  = 1'b0;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        check("bp release ready", start_ready, 1'b1);
        check("bp release busy", busy, 1'b0);
        @(posedge clk);
        #1;
        check("bp not queued", busy, 1'b0);

        // Flush in IDLE together with a request rejects it
        @(negedge clk);
        start_valid = 1'b1;
        flush       = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        flush       = 1'b0;
        check("idle flush busy", busy, 1'b0);
        check("idle flush ready", start_ready, 1'b1);

        // Flush during CALC
        start_op(OP_MUL, 32'd5, 32'd5);
        repeat (4) @(posedge clk);
        #1;
        check("calc busy", busy, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush busy", busy, 1'b0);
        check("flush ready", start_ready, 1'b1);
        check("flush valid", result_valid, 1'b0);
        expect_silence("flush", LAT + 6);

        // Reset asserted while in FIX
        start_op(OP_MUL, 32'd9, 32'd9);
        cycles = 1;
        while (cycles < W + 1) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("fix busy", busy, 1'b1);
        check("fix no valid yet", result_valid, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst ready", start_ready, 1'b1);
        check("midrst busy", busy, 1'b0);
        check("midrst valid", result_valid, 1'b0);
        check("midrst result", result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_silence("midrst", LAT + 6);

        // Normal operation after the aborts
        run_op("mul 3x4", OP_MUL, 32'd3, 32'd4, 32'd12, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
